// File: rtl/system_acl_iface_key_pio_if.sv
// Avalon-MM register-slave bus shared by the ACL interface PIOs.
// Carries the word-addressed read/write channel and the level interrupt.
interface system_acl_iface_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/system_acl_iface_key_pio.sv
// Key/switch input PIO: synchronizer and per-bit debounce feed a sticky edge
// capture register with a masked level interrupt, on a 4-word Avalon-MM slave.
module system_acl_iface_key_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int RESET_LEVEL     = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_port,
    system_acl_iface_key_pio_if.slave bus
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] LVL_RST  = (RESET_LEVEL != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cap_nxt;
    logic [WIDTH-1:0] mask_nxt;
    logic [31:0]      rd_nxt;
    logic             wr_en;
    logic             unused_wdata;

    // Debounce: a bit is accepted only after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i] + 1'b1;
            if (sync_p1[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_TERM) begin
                accept[i]  = 1'b1;
                cnt_nxt[i] = '0;
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = accept & sync_p1;
            1:       edge_hit = accept & ~sync_p1;
            default: edge_hit = accept;
        endcase
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    // Set has priority over a same-cycle W1C clear
    always_comb begin
        clr      = '0;
        mask_nxt = mask;
        if (wr_en && bus.address == 2'd3) clr      = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == 2'd1) mask_nxt = bus.writedata[WIDTH-1:0];
        cap_nxt = (cap & ~clr) | edge_hit;
    end

    always_comb begin
        case (bus.address)
            2'd0:    rd_nxt = 32'(stable);
            2'd1:    rd_nxt = 32'(mask);
            2'd3:    rd_nxt = 32'(cap);
            default: rd_nxt = '0;
        endcase
    end

    // Stage p0/p1: two-flop synchronizer, then debounce and register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0      <= LVL_RST;
            sync_p1      <= LVL_RST;
            stable       <= LVL_RST;
            mask         <= '0;
            cap          <= '0;
            bus.readdata <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync_p0      <= in_port;
            sync_p1      <= sync_p0;
            stable       <= stable ^ accept;
            mask         <= mask_nxt;
            cap          <= cap_nxt;
            bus.readdata <= rd_nxt;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    assign bus.irq = |(cap & mask);

endmodule
